// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encodings and default sizing for dmem_responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rsp_state_e;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array with synchronous write and registered read
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; read data only updates when re_i is pulsed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store target with programmable latency and error response
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [7:0] WAIT_INIT = ZERO_WAIT ? 8'd0 : 8'(WAIT_CYCLES - 1);

    rsp_state_e       state_q;
    logic [7:0]       wait_q;
    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rd_sel_q;

    logic             req_fire;
    logic             req_err;
    logic             access_en;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [31:0]      arr_rdata;

    // Decode the incoming request and steer the array: a zero-latency access in IDLE
    // uses the live request, a delayed access uses the captured copy.
    always_comb begin
        req_fire  = req_valid & req_ready_q;
        // Full 30-bit word index is compared so high address bits never alias into the array.
        req_err   = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr[31:2]} >= 31'(DEPTH_WORDS));
        access_en = (req_fire & ~req_err & ZERO_WAIT)
                  | ((state_q == RSP_WAIT) && (wait_q == 8'd0));
        if (state_q == RSP_IDLE) begin
            acc_we    = req_we;
            acc_idx   = req_addr[IDX_W+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (access_en & acc_we),
        .re_i   (access_en & ~acc_we),
        .idx_i  (acc_idx),
        .wdata_i(acc_wdata),
        .rdata_o(arr_rdata)
    );

    // Request/response FSM with registered handshake outputs and wait counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RSP_IDLE;
            wait_q      <= 8'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    if (req_fire) begin
                        we_q        <= req_we;
                        idx_q       <= req_addr[IDX_W+1:2];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q     <= RSP_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rd_sel_q    <= 1'b0;
                        end else if (ZERO_WAIT) begin
                            state_q     <= RSP_RESP;
                            rsp_valid_q <= 1'b1;
                            rd_sel_q    <= ~req_we;
                        end else begin
                            state_q <= RSP_WAIT;
                            wait_q  <= WAIT_INIT;
                        end
                    end
                end
                RSP_WAIT: begin
                    if (wait_q == 8'd0) begin
                        state_q     <= RSP_RESP;
                        rsp_valid_q <= 1'b1;
                        rd_sel_q    <= ~we_q;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                RSP_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= RSP_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_sel_q    <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= RSP_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rd_sel_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Load data is only exposed while a successful load response is held.
    assign rsp_rdata = rd_sel_q ? arr_rdata : 32'd0;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
